// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_pkg
// Brief    : Shared widths, saturation bounds and signed saturation helper
//            for the partial-sum requantization stage.
// Revision : 1.0 - initial release
// ============================================================================
package psum_pkg;

   localparam int COLUMN = 6;   // MAC columns processed in parallel
   localparam int OW     = 22;  // partial-sum width per column
   localparam int AW     = 32;  // accumulator width per column
   localparam int BW     = 32;  // bias width per column
   localparam int QW     = 8;   // quantized output width per column
   localparam int SW     = 5;   // shift-amount width

   localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
   localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));
   localparam longint Q_MAX   = (64'sd1 <<< (QW - 1)) - 64'sd1;
   localparam longint Q_MIN   = -(64'sd1 <<< (QW - 1));

   // Clamp a signed value into the range of a signed integer of 'width' bits.
   function automatic longint sat_signed(input longint value, input int width);
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) begin
         sat_signed = hi;
      end else if (value < lo) begin
         sat_signed = lo;
      end else begin
         sat_signed = value;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/psum_requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : One column of the requantizer. Saturates the raw accumulator sum
//            to AW bits (reporting any clip), then adds bias, applies a
//            round-half-up arithmetic right shift, optional ReLU and clamps to
//            the QW-bit signed range. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module requant_lane #(
   parameter int AW = 32,
   parameter int BW = 32,
   parameter int QW = 8,
   parameter int SW = 5
) (
   input  logic signed [AW:0]    sum,      // base + psum, one guard bit
   input  logic signed [BW-1:0]  bias,
   input  logic        [SW-1:0]  shift,
   input  logic                  relu_en,
   output logic signed [AW-1:0]  acc_sat,  // sum clamped to the AW range
   output logic signed [QW-1:0]  q,
   output logic                  clip      // accumulator range was exceeded
);

   import psum_pkg::*;

   longint s_wide;
   longint s_sat;
   longint t_wide;
   longint r_wide;

   // Accumulator saturation followed by bias, rounding shift, ReLU and clamp.
   // 64-bit intermediates leave headroom for the rounding increment on top
   // of a full-scale sum plus bias.
   always_comb begin
      s_wide  = longint'(sum);
      s_sat   = sat_signed(s_wide, AW);
      clip    = (s_sat != s_wide);
      acc_sat = AW'(s_sat);

      t_wide = s_sat + longint'(bias);
      if (shift != '0) begin
         t_wide = t_wide + (64'sd1 <<< (shift - SW'(1)));
      end
      r_wide = t_wide >>> shift;
      if (relu_en && (r_wide < 0)) begin
         r_wide = 0;
      end
      q = QW'(sat_signed(r_wide, QW));
   end

endmodule
`default_nettype wire

// File: rtl/psum_requant.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant
// Brief    : Accumulates per-column partial sums over the beats of one output
//            pixel, adds a per-pixel latched bias and requantizes each column
//            to QW bits. One-deep output register with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module psum_requant #(
   parameter int COLUMN = psum_pkg::COLUMN,
   parameter int OW     = psum_pkg::OW,
   parameter int AW     = psum_pkg::AW,
   parameter int BW     = psum_pkg::BW,
   parameter int QW     = psum_pkg::QW,
   parameter int SW     = psum_pkg::SW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [COLUMN*OW-1:0]  psum_m_data,
   input  logic                  psum_m_first,
   input  logic                  psum_m_last,
   input  logic                  psum_m_valid,
   output logic                  psum_m_ready,
   input  logic [COLUMN*BW-1:0]  bias,
   input  logic [SW-1:0]         shift,
   input  logic                  relu_en,
   output logic [COLUMN*QW-1:0]  q_s_data,
   output logic                  q_s_valid,
   input  logic                  q_s_ready,
   output logic                  ovf_flag,
   input  logic                  ovf_clr,
   output logic [15:0]           pix_cnt
);

   import psum_pkg::*;

   logic [COLUMN-1:0][AW-1:0] acc_q, acc_d;
   logic [COLUMN*BW-1:0]      bias_q, bias_d;
   logic [SW-1:0]             shift_q, shift_d;
   logic                      relu_q, relu_d;
   logic [COLUMN*QW-1:0]      q_data_q, q_data_d;
   logic                      q_valid_q, q_valid_d;
   logic                      ovf_q, ovf_d;
   logic [15:0]               pix_cnt_q, pix_cnt_d;
   logic                      rdy_en_q, rdy_en_d;

   logic                      accept;
   logic                      q_hs;
   logic [COLUMN*BW-1:0]      eff_bias;
   logic [SW-1:0]             eff_shift;
   logic                      eff_relu;
   logic [COLUMN-1:0][AW-1:0] acc_sat;
   logic [COLUMN*QW-1:0]      q_lane;
   logic [COLUMN-1:0]         clip;

   // rdy_en_q keeps the input closed until the first clock after reset.
   assign psum_m_ready = rdy_en_q && (!q_valid_q || q_s_ready);
   assign accept       = psum_m_valid && psum_m_ready;
   assign q_hs         = q_valid_q && q_s_ready;

   // A single-beat pixel must see its own config, so a first beat bypasses
   // the latch; later beats use the copy captured on the first beat.
   assign eff_bias  = psum_m_first ? bias    : bias_q;
   assign eff_shift = psum_m_first ? shift   : shift_q;
   assign eff_relu  = psum_m_first ? relu_en : relu_q;

   generate
      for (genvar c = 0; c < COLUMN; c++) begin : g_lane
         logic [AW-1:0] base;
         logic [AW:0]   sum;

         assign base = psum_m_first ? '0 : acc_q[c];
         assign sum  = {base[AW-1], base}
                     + {{(AW + 1 - OW){psum_m_data[c*OW + OW - 1]}}, psum_m_data[c*OW +: OW]};

         requant_lane #(
            .AW (AW),
            .BW (BW),
            .QW (QW),
            .SW (SW)
         ) u_lane (
            .sum     (sum),
            .bias    (eff_bias[c*BW +: BW]),
            .shift   (eff_shift),
            .relu_en (eff_relu),
            .acc_sat (acc_sat[c]),
            .q       (q_lane[c*QW +: QW]),
            .clip    (clip[c])
         );
      end
   endgenerate

   // Next-state: accumulators, config latch, output register, flags, counter.
   always_comb begin
      acc_d     = acc_q;
      bias_d    = bias_q;
      shift_d   = shift_q;
      relu_d    = relu_q;
      q_data_d  = q_data_q;
      q_valid_d = q_valid_q;
      ovf_d     = ovf_q;
      pix_cnt_d = pix_cnt_q + {15'd0, q_hs};
      rdy_en_d  = 1'b1;

      if (q_hs) begin
         q_valid_d = 1'b0;
      end
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (accept) begin
         for (int c = 0; c < COLUMN; c++) begin
            acc_d[c] = psum_m_last ? '0 : acc_sat[c];
         end
         if (psum_m_first) begin
            bias_d  = bias;
            shift_d = shift;
            relu_d  = relu_en;
         end
         if (psum_m_last) begin
            q_data_d  = q_lane;
            q_valid_d = 1'b1;
         end
         if (|clip) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         bias_q    <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         q_data_q  <= '0;
         q_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         pix_cnt_q <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         bias_q    <= bias_d;
         shift_q   <= shift_d;
         relu_q    <= relu_d;
         q_data_q  <= q_data_d;
         q_valid_q <= q_valid_d;
         ovf_q     <= ovf_d;
         pix_cnt_q <= pix_cnt_d;
         rdy_en_q  <= rdy_en_d;
      end
   end

   assign q_s_data  = q_data_q;
   assign q_s_valid = q_valid_q;
   assign ovf_flag  = ovf_q;
   assign pix_cnt   = pix_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_requant
// Brief    : Self-checking bench for psum_requant: directed cases plus random
//            pixels, with a queue-based scoreboard fed by a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_requant;

   localparam int COLUMN = 6;
   localparam int OW     = 22;
   localparam int AW     = 32;
   localparam int BW     = 32;
   localparam int QW     = 8;
   localparam int SW     = 5;
   localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
   localparam longint AMIN = -(64'sd1 <<< (AW - 1));

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [COLUMN*OW-1:0] psum_m_data = '0;
   logic                 psum_m_first = 1'b0;
   logic                 psum_m_last = 1'b0;
   logic                 psum_m_valid = 1'b0;
   logic                 psum_m_ready;
   logic [COLUMN*BW-1:0] bias = '0;
   logic [SW-1:0]        shift = '0;
   logic                 relu_en = 1'b0;
   logic [COLUMN*QW-1:0] q_s_data;
   logic                 q_s_valid;
   logic                 q_s_ready = 1'b1;
   logic                 ovf_flag;
   logic                 ovf_clr = 1'b0;
   logic [15:0]          pix_cnt;

   psum_requant #(
      .COLUMN (COLUMN), .OW (OW), .AW (AW), .BW (BW), .QW (QW), .SW (SW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .psum_m_data  (psum_m_data),
      .psum_m_first (psum_m_first),
      .psum_m_last  (psum_m_last),
      .psum_m_valid (psum_m_valid),
      .psum_m_ready (psum_m_ready),
      .bias         (bias),
      .shift        (shift),
      .relu_en      (relu_en),
      .q_s_data     (q_s_data),
      .q_s_valid    (q_s_valid),
      .q_s_ready    (q_s_ready),
      .ovf_flag     (ovf_flag),
      .ovf_clr      (ovf_clr),
      .pix_cnt      (pix_cnt)
   );

   initial forever #5 clk = ~clk;

   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  hs_seen = 0;
   bit  rand_mode = 0;

   // reference model state
   longint m_acc  [COLUMN];
   longint m_bias [COLUMN];
   int     m_shift = 0;
   bit     m_relu = 0;
   bit     ovf_exp = 0;
   logic [COLUMN*QW-1:0] exp_q[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [COLUMN*OW-1:0] col0(input longint v);
      logic [COLUMN*OW-1:0] d;
      d = '0;
      d[OW-1:0] = v[OW-1:0];
      return d;
   endfunction

   // Apply one accepted beat to the model; push a pixel when it completes.
   task automatic model_accept();
      logic [COLUMN*QW-1:0] qv;
      longint s, cs, t, r;
      if (psum_m_first) begin
         for (int c = 0; c < COLUMN; c++) m_bias[c] = sx(longint'(bias[c*BW +: BW]), BW);
         m_shift = int'(shift);
         m_relu  = relu_en;
      end
      qv = '0;
      for (int c = 0; c < COLUMN; c++) begin
         s  = (psum_m_first ? 64'sd0 : m_acc[c]) + sx(longint'(psum_m_data[c*OW +: OW]), OW);
         cs = clamp(s, AMIN, AMAX);
         if (cs != s) ovf_exp = 1;
         if (psum_m_last) begin
            t = cs + m_bias[c];
            if (m_shift > 0) t = t + (64'sd1 <<< (m_shift - 1));
            r = t >>> m_shift;
            if (m_relu && r < 0) r = 0;
            r = clamp(r, -128, 127);
            qv[c*QW +: QW] = r[QW-1:0];
            m_acc[c] = 0;
         end else begin
            m_acc[c] = cs;
         end
      end
      if (psum_m_last) exp_q.push_back(qv);
   endtask

   // Present one beat; called at posedge+1, returns at posedge+1 after accept.
   task automatic send_beat(input logic [COLUMN*OW-1:0] d, input logic f, input logic l);
      int waited;
      bit ok;
      waited = 0;
      ok = 0;
      psum_m_data  = d;
      psum_m_first = f;
      psum_m_last  = l;
      psum_m_valid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         if (psum_m_ready === 1'b1) begin
            ok = 1;
         end else begin
            waited++;
            if (waited > 1000) begin
               n_chk++;
               n_fail++;
               $display("FAIL accept_timeout: got ready=0 for %0d cycles expected accept", waited);
               break;
            end
         end
      end
      if (ok) begin
         @(posedge clk);
         model_accept();
      end
      #1;
      psum_m_valid = 1'b0;
      psum_m_first = 1'b0;
      psum_m_last  = 1'b0;
   endtask

   task automatic expect_q0(input string name, input longint v);
      logic [QW-1:0] b;
      @(negedge clk);
      chk({name, "_valid"}, longint'(q_s_valid), 1);
      b = q_s_data[QW-1:0];
      chk(name, sx(longint'(b), QW), v);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      psum_m_valid = 1'b0;
      exp_q.delete();
      hs_seen = 0;
      ovf_exp = 0;
      for (int c = 0; c < COLUMN; c++) begin
         m_acc[c]  = 0;
         m_bias[c] = 0;
      end
      m_shift = 0;
      m_relu  = 0;
      repeat (cycles) begin
         @(negedge clk);
         chk("rst_q_data",  longint'(q_s_data), 0);
         chk("rst_q_valid", longint'(q_s_valid), 0);
         chk("rst_ovf",     longint'(ovf_flag), 0);
         chk("rst_pix_cnt", longint'(pix_cnt), 0);
         chk("rst_ready",   longint'(psum_m_ready), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_at_release", longint'(psum_m_ready), 0);
      @(negedge clk);
      chk("ready_after_release", longint'(psum_m_ready), 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output handshake and tracks flags.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("pix_cnt", longint'(pix_cnt), longint'(16'(hs_seen)));
         chk("ovf_flag", longint'(ovf_flag), longint'(ovf_exp));
         if (q_s_valid && q_s_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL q_unexpected: got pixel %h expected none", q_s_data);
            end else begin
               chk("q_data", longint'(q_s_data), longint'(exp_q.pop_front()));
            end
            hs_seen++;
         end
      end
   end

   // Random downstream backpressure during the random phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_mode) q_s_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int nb;
      longint v;
      logic [COLUMN*OW-1:0] d;

      for (int c = 0; c < COLUMN; c++) begin
         m_acc[c]  = 0;
         m_bias[c] = 0;
      end
      do_reset(3);

      // multi-beat pixel: (100+200+300 + 4) >> 3 = 75
      shift = 5'd3;
      send_beat(col0(100), 1, 0);
      send_beat(col0(200), 0, 0);
      send_beat(col0(300), 0, 1);
      expect_q0("t1_q", 75);
      @(negedge clk);
      chk("t1_pix_cnt", longint'(pix_cnt), 1);
      @(posedge clk); #1;

      // rounding and ReLU
      shift = 5'd1;
      send_beat(col0(-5), 1, 1);
      expect_q0("round_neg", -2);
      @(posedge clk); #1;
      relu_en = 1'b1;
      send_beat(col0(-5), 1, 1);
      expect_q0("relu_neg", 0);
      @(posedge clk); #1;
      relu_en = 1'b0;

      // output saturation and bias
      shift = 5'd0;
      send_beat(col0(4000), 1, 1);
      expect_q0("sat_pos", 127);
      @(posedge clk); #1;
      send_beat(col0(-4000), 1, 1);
      expect_q0("sat_neg", -128);
      @(posedge clk); #1;
      bias[BW-1:0] = -32'sd60;
      send_beat(col0(50), 1, 1);
      expect_q0("bias_neg", -10);
      @(posedge clk); #1;
      bias = '0;

      // accumulator saturation
      for (int i = 0; i < 1100; i++) send_beat(col0(2097151), i == 0, i == 1099);
      expect_q0("acc_sat_q", 127);
      chk("acc_sat_ovf", longint'(ovf_flag), 1);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk);
      ovf_exp = 0;
      #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("ovf_cleared", longint'(ovf_flag), 0);
      @(posedge clk); #1;

      // backpressure: output held, input stalled, nothing lost
      q_s_ready = 1'b0;
      send_beat(col0(11), 1, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_ready_low", longint'(psum_m_ready), 0);
         chk("bp_valid_hold", longint'(q_s_valid), 1);
         chk("bp_data_hold", longint'(q_s_data), 11);
      end
      @(posedge clk); #1;
      fork
         send_beat(col0(22), 1, 1);
         begin
            repeat (2) @(posedge clk);
            #1;
            q_s_ready = 1'b1;
         end
      join
      expect_q0("bp_second", 22);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_drain", exp_q.size(), 0);

      // throughput: one single-beat pixel per cycle
      c0 = cyc;
      for (int i = 0; i < 4; i++) send_beat(col0(i * 3 - 4), 1, 1);
      chk("tput_cycles", cyc - c0, 4);
      repeat (3) @(posedge clk);
      #1;

      // reset drops a pending output
      q_s_ready = 1'b0;
      send_beat(col0(33), 1, 1);
      do_reset(2);
      q_s_ready = 1'b1;
      // reset drops a partial accumulation
      send_beat(col0(7), 1, 0);
      send_beat(col0(9), 0, 0);
      do_reset(2);
      shift = 5'd0;
      bias  = '0;
      send_beat(col0(10), 1, 0);
      send_beat(col0(20), 0, 1);
      expect_q0("post_reset", 30);
      @(posedge clk); #1;

      // random pixels against the model
      rand_mode = 1;
      for (int p = 0; p < 150; p++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int c = 0; c < COLUMN; c++) begin
               if ($urandom_range(0, 3) == 0) v = longint'($urandom);
               else v = longint'(int'($urandom_range(0, 1023)) - 512);
               d[c*OW +: OW] = v[OW-1:0];
               if ($urandom_range(0, 2) == 0) bias[c*BW +: BW] = $urandom;
               else bias[c*BW +: BW] = 32'(int'($urandom_range(0, 2000)) - 1000);
            end
            shift   = ($urandom_range(0, 5) == 0) ? SW'($urandom_range(13, 31))
                                                 : SW'($urandom_range(0, 12));
            relu_en = $urandom_range(0, 1) == 1;
            send_beat(d,
                      (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0),
                      b == nb - 1);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
      end
      rand_mode = 0;
      @(posedge clk);
      #1;
      q_s_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("random_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
